// File: rtl/ibex_rf_wr_arbiter_if.sv
// Handshake bundle between the three RF write producers, the ID read ports and the write arbiter.
// The slave modport is the arbiter's view; the master modport is the producer/ID/RF side.
interface ibex_rf_wr_arbiter_if;
    logic        lsu_we_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        aux_valid_i;
    logic        aux_ready_o;
    logic [4:0]  aux_waddr_i;
    logic [31:0] aux_wdata_i;
    logic [4:0]  rd_addr_a_i;
    logic [4:0]  rd_addr_b_i;
    logic        hazard_a_o;
    logic        hazard_b_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    modport slave (
        input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
        input  ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  aux_valid_i, aux_waddr_i, aux_wdata_i,
        input  rd_addr_a_i, rd_addr_b_i,
        output ex_ready_o, aux_ready_o, hazard_a_o, hazard_b_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport master (
        output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
        output ex_valid_i, ex_waddr_i, ex_wdata_i,
        output aux_valid_i, aux_waddr_i, aux_wdata_i,
        output rd_addr_a_i, rd_addr_b_i,
        input  ex_ready_o, aux_ready_o, hazard_a_o, hazard_b_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter: LSU absolute priority, EX/AUX round-robin, registered write.
// Optional stall counters are built when IBEX_RF_WR_ARB_PERF_EN is defined.
//
// state     | meaning
// LAST_EX   | EX won the most recent EX/AUX grant; AUX wins the next tie
// LAST_AUX  | AUX won the most recent EX/AUX grant; EX wins the next tie
module ibex_rf_wr_arbiter #(
    parameter bit ResetAll   = 1'b0,
    parameter bit AuxPresent = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
`ifdef IBEX_RF_WR_ARB_PERF_EN
    input  logic                 perf_clr_i,
    output logic [15:0]          perf_ex_stall_o,
    output logic [15:0]          perf_aux_stall_o,
`endif
    ibex_rf_wr_arbiter_if.slave  bus
);

    typedef enum logic {LAST_EX = 1'b0, LAST_AUX = 1'b1} state_e;

    state_e      r_last_q;
    state_e      w_last_d;
    logic        w_aux_valid;
    logic        w_ex_gnt;
    logic        w_aux_gnt;
    logic        w_we_d;
    logic [4:0]  w_waddr_d;
    logic [31:0] w_wdata_d;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;

    assign w_aux_valid = AuxPresent ? bus.aux_valid_i : 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_q <= LAST_EX;
        end else begin
            r_last_q <= w_last_d;
        end
    end

    always_comb begin
        w_last_d  = r_last_q;
        w_ex_gnt  = 1'b0;
        w_aux_gnt = 1'b0;
        if (!bus.lsu_we_i) begin
            if (bus.ex_valid_i && w_aux_valid) begin
                if (r_last_q == LAST_EX) begin
                    w_aux_gnt = 1'b1;
                    w_last_d  = LAST_AUX;
                end else begin
                    w_ex_gnt  = 1'b1;
                    w_last_d  = LAST_EX;
                end
            end else if (bus.ex_valid_i) begin
                w_ex_gnt = 1'b1;
                w_last_d = LAST_EX;
            end else if (w_aux_valid) begin
                w_aux_gnt = 1'b1;
                w_last_d  = LAST_AUX;
            end
        end
    end

    assign bus.ex_ready_o  = w_ex_gnt;
    assign bus.aux_ready_o = w_aux_gnt;

    always_comb begin
        w_waddr_d = bus.lsu_waddr_i;
        w_wdata_d = bus.lsu_wdata_i;
        if (w_ex_gnt) begin
            w_waddr_d = bus.ex_waddr_i;
            w_wdata_d = bus.ex_wdata_i;
        end else if (w_aux_gnt) begin
            w_waddr_d = bus.aux_waddr_i;
            w_wdata_d = bus.aux_wdata_i;
        end
    end

    // x0 grants still complete the handshake but never reach the register file
    assign w_we_d = (bus.lsu_we_i || w_ex_gnt || w_aux_gnt) && (w_waddr_d != 5'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rf_we <= 1'b0;
        end else begin
            r_rf_we <= w_we_d;
        end
    end

    generate
        if (ResetAll) begin : g_data_rst
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_rf_waddr <= 5'd0;
                    r_rf_wdata <= 32'd0;
                end else if (w_we_d) begin
                    r_rf_waddr <= w_waddr_d;
                    r_rf_wdata <= w_wdata_d;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk_i) begin
                if (w_we_d) begin
                    r_rf_waddr <= w_waddr_d;
                    r_rf_wdata <= w_wdata_d;
                end
            end
        end
    endgenerate

    assign bus.rf_we_o    = r_rf_we;
    assign bus.rf_waddr_o = r_rf_waddr;
    assign bus.rf_wdata_o = r_rf_wdata;

    logic w_ex_wait;
    logic w_aux_wait;
    assign w_ex_wait  = bus.ex_valid_i & ~w_ex_gnt;
    assign w_aux_wait = w_aux_valid & ~w_aux_gnt;

    assign bus.hazard_a_o = (bus.rd_addr_a_i != 5'd0) &&
                            ((w_ex_wait  && (bus.ex_waddr_i  == bus.rd_addr_a_i)) ||
                             (w_aux_wait && (bus.aux_waddr_i == bus.rd_addr_a_i)));
    assign bus.hazard_b_o = (bus.rd_addr_b_i != 5'd0) &&
                            ((w_ex_wait  && (bus.ex_waddr_i  == bus.rd_addr_b_i)) ||
                             (w_aux_wait && (bus.aux_waddr_i == bus.rd_addr_b_i)));

`ifdef IBEX_RF_WR_ARB_PERF_EN
    logic [15:0] r_perf_ex;
    logic [15:0] r_perf_aux;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_ex  <= 16'd0;
            r_perf_aux <= 16'd0;
        end else if (perf_clr_i) begin
            r_perf_ex  <= 16'd0;
            r_perf_aux <= 16'd0;
        end else begin
            if (w_ex_wait && (r_perf_ex != 16'hFFFF)) begin
                r_perf_ex <= r_perf_ex + 16'd1;
            end
            if (w_aux_wait && (r_perf_aux != 16'hFFFF)) begin
                r_perf_aux <= r_perf_aux + 16'd1;
            end
        end
    end

    assign perf_ex_stall_o  = r_perf_ex;
    assign perf_aux_stall_o = r_perf_aux;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($onehot0({bus.lsu_we_i, w_ex_gnt, w_aux_gnt}));
        end
    end
`endif

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Directed bench for ibex_rf_wr_arbiter: priority, round-robin, x0, hazards and async reset.
module tb_ibex_rf_wr_arbiter;

    logic clk_i;
    logic rst_ni;
    int   n_tests;
    int   n_fail;

    ibex_rf_wr_arbiter_if bus ();

`ifdef IBEX_RF_WR_ARB_PERF_EN
    logic        perf_clr_i;
    logic [15:0] perf_ex_stall_o;
    logic [15:0] perf_aux_stall_o;
`endif

    ibex_rf_wr_arbiter dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
`ifdef IBEX_RF_WR_ARB_PERF_EN
        .perf_clr_i       (perf_clr_i),
        .perf_ex_stall_o  (perf_ex_stall_o),
        .perf_aux_stall_o (perf_aux_stall_o),
`endif
        .bus              (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.lsu_we_i    = 1'b0;
        bus.lsu_waddr_i = 5'd0;
        bus.lsu_wdata_i = 32'd0;
        bus.ex_valid_i  = 1'b0;
        bus.ex_waddr_i  = 5'd0;
        bus.ex_wdata_i  = 32'd0;
        bus.aux_valid_i = 1'b0;
        bus.aux_waddr_i = 5'd0;
        bus.aux_wdata_i = 32'd0;
        bus.rd_addr_a_i = 5'd0;
        bus.rd_addr_b_i = 5'd0;
    endtask

    // inputs change at negedge; combinational outputs checked 1ns later, registered ones 1ns after posedge
    task automatic to_post();
        @(posedge clk_i);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk_i);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
`ifdef IBEX_RF_WR_ARB_PERF_EN
        perf_clr_i = 1'b0;
`endif
        rst_ni = 1'b0;
        #1;
        chk("reset_rf_we",     32'(bus.rf_we_o),     32'd0);
        chk("reset_ex_ready",  32'(bus.ex_ready_o),  32'd0);
        chk("reset_aux_ready", 32'(bus.aux_ready_o), 32'd0);
        repeat (2) to_neg();
        rst_ni = 1'b1;

        // EX only
        bus.ex_valid_i = 1'b1;
        bus.ex_waddr_i = 5'd5;
        bus.ex_wdata_i = 32'hA5A5_0001;
        #1;
        chk("exonly_ready",     32'(bus.ex_ready_o),  32'd1);
        chk("exonly_aux_ready", 32'(bus.aux_ready_o), 32'd0);
        to_post();
        chk("exonly_we",    32'(bus.rf_we_o),    32'd1);
        chk("exonly_waddr", 32'(bus.rf_waddr_o), 32'd5);
        chk("exonly_wdata", bus.rf_wdata_o,      32'hA5A5_0001);
        to_neg();
        idle_inputs();
        to_post();
        chk("idle_we", 32'(bus.rf_we_o), 32'd0);
        chk("idle_waddr_hold", 32'(bus.rf_waddr_o), 32'd5);

        // LSU collides with EX
        to_neg();
        bus.lsu_we_i    = 1'b1;
        bus.lsu_waddr_i = 5'd3;
        bus.lsu_wdata_i = 32'h0000_1234;
        bus.ex_valid_i  = 1'b1;
        bus.ex_waddr_i  = 5'd7;
        bus.ex_wdata_i  = 32'h0000_0077;
        bus.rd_addr_a_i = 5'd7;
        bus.rd_addr_b_i = 5'd3;
        #1;
        chk("lsu_ex_ready", 32'(bus.ex_ready_o), 32'd0);
        chk("lsu_hazard_a", 32'(bus.hazard_a_o), 32'd1);
        chk("lsu_hazard_b", 32'(bus.hazard_b_o), 32'd0);
        to_post();
        chk("lsu_we",    32'(bus.rf_we_o),    32'd1);
        chk("lsu_waddr", 32'(bus.rf_waddr_o), 32'd3);
        chk("lsu_wdata", bus.rf_wdata_o,      32'h0000_1234);
        to_neg();
        bus.lsu_we_i = 1'b0;
        #1;
        chk("after_lsu_ex_ready", 32'(bus.ex_ready_o), 32'd1);
        chk("after_lsu_hazard_a", 32'(bus.hazard_a_o), 32'd0);
        to_post();
        chk("after_lsu_waddr", 32'(bus.rf_waddr_o), 32'd7);
        chk("after_lsu_wdata", bus.rf_wdata_o,      32'h0000_0077);
        to_neg();
        idle_inputs();

        // round-robin: last grant was EX, so AUX, EX, AUX, EX
        bus.ex_valid_i  = 1'b1;
        bus.ex_waddr_i  = 5'd10;
        bus.ex_wdata_i  = 32'h0000_0A0A;
        bus.aux_valid_i = 1'b1;
        bus.aux_waddr_i = 5'd20;
        bus.aux_wdata_i = 32'h0000_1414;
        bus.rd_addr_a_i = 5'd10;
        bus.rd_addr_b_i = 5'd20;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_aux_ready", 32'(bus.aux_ready_o), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ex_ready",  32'(bus.ex_ready_o),  (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_hazard_a",  32'(bus.hazard_a_o),  (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_hazard_b",  32'(bus.hazard_b_o),  (i % 2 == 0) ? 32'd0 : 32'd1);
            to_post();
            chk("rr_waddr", 32'(bus.rf_waddr_o), (i % 2 == 0) ? 32'd20 : 32'd10);
            to_neg();
        end
        idle_inputs();

        // x0 write
        bus.ex_valid_i = 1'b1;
        bus.ex_waddr_i = 5'd0;
        bus.ex_wdata_i = 32'hDEAD_BEEF;
        #1;
        chk("x0_ready", 32'(bus.ex_ready_o), 32'd1);
        to_post();
        chk("x0_we",        32'(bus.rf_we_o),    32'd0);
        chk("x0_waddr_hold", 32'(bus.rf_waddr_o), 32'd10);
        to_neg();
        idle_inputs();

        // AUX grant then reset mid-operation
        bus.aux_valid_i = 1'b1;
        bus.aux_waddr_i = 5'd9;
        bus.aux_wdata_i = 32'h0000_0909;
        #1;
        chk("aux_only_ready", 32'(bus.aux_ready_o), 32'd1);
        to_post();
        chk("aux_only_we",    32'(bus.rf_we_o),    32'd1);
        chk("aux_only_waddr", 32'(bus.rf_waddr_o), 32'd9);
        to_neg();
        idle_inputs();
        rst_ni = 1'b0;
        #1;
        chk("midreset_we", 32'(bus.rf_we_o), 32'd0);
        to_neg();
        rst_ni = 1'b1;
        bus.ex_valid_i  = 1'b1;
        bus.ex_waddr_i  = 5'd11;
        bus.ex_wdata_i  = 32'h0000_0B0B;
        bus.aux_valid_i = 1'b1;
        bus.aux_waddr_i = 5'd12;
        bus.aux_wdata_i = 32'h0000_0C0C;
        #1;
        chk("postreset_aux_ready", 32'(bus.aux_ready_o), 32'd1);
        chk("postreset_ex_ready",  32'(bus.ex_ready_o),  32'd0);
        to_post();
        chk("postreset_waddr", 32'(bus.rf_waddr_o), 32'd12);
        chk("postreset_wdata", bus.rf_wdata_o,      32'h0000_0C0C);
        to_neg();
        idle_inputs();

`ifdef IBEX_RF_WR_ARB_PERF_EN
        perf_clr_i = 1'b1;
        to_neg();
        perf_clr_i = 1'b0;
        bus.lsu_we_i    = 1'b1;
        bus.lsu_waddr_i = 5'd1;
        bus.aux_valid_i = 1'b1;
        bus.aux_waddr_i = 5'd2;
        repeat (70000) to_neg();
        chk("perf_aux_sat", 32'(perf_aux_stall_o), 32'h0000_FFFF);
        chk("perf_ex_zero", 32'(perf_ex_stall_o),  32'd0);
        idle_inputs();
        perf_clr_i = 1'b1;
        to_neg();
        perf_clr_i = 1'b0;
        chk("perf_aux_clr", 32'(perf_aux_stall_o), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_rf_wr_arbiter.md
Name: ibex_rf_wr_arbiter

Overview:
- Arbitrates the single register-file write port between three producers: LSU load data, the ID/EX result path and an auxiliary long-latency unit (divider/coprocessor).
- Sits between the writeback passthrough and the register file.
- Grants one writer per cycle, registers the winning write, and reports read hazards against writers still waiting for a grant.

Parameters:
- ResetAll, 1'b0, when 1 the data/address output flops are also asynchronously reset; when 0 only the control flops are reset.
- AuxPresent, 1'b1, when 0 the aux requester is tied off: aux_ready_o=0 and aux contributes no hazards.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- lsu_we_i  input  1  LSU load write this cycle; no backpressure, must be accepted
- lsu_waddr_i  input  5  LSU destination register
- lsu_wdata_i  input  32  LSU load data
- ex_valid_i  input  1  ID/EX write request
- ex_ready_o  output  1  ID/EX request granted this cycle
- ex_waddr_i  input  5  ID/EX destination
- ex_wdata_i  input  32  ID/EX data
- aux_valid_i  input  1  aux unit write request
- aux_ready_o  output  1  aux request granted this cycle
- aux_waddr_i  input  5  aux destination
- aux_wdata_i  input  32  aux data
- rd_addr_a_i  input  5  ID read port A address
- rd_addr_b_i  input  5  ID read port B address
- hazard_a_o  output  1  port A matches a pending, ungranted writer
- hazard_b_o  output  1  port B matches a pending, ungranted writer
- rf_we_o  output  1  registered RF write enable
- rf_waddr_o  output  5  registered RF write address
- rf_wdata_o  output  32  registered RF write data

Behaviour:
- Reset values:
  - rf_we_o=0.
  - rf_waddr_o=0 and rf_wdata_o=0 when ResetAll; otherwise these are undefined until the first grant.
  - Round-robin pointer last_q=EX.
  - ex_ready_o and aux_ready_o are combinational and evaluate to 0 while no request is valid.
- Priority:
  - LSU is absolute highest priority. When lsu_we_i=1, the LSU is granted, ex_ready_o=0, aux_ready_o=0, and last_q is unchanged.
- Round-robin between EX and AUX, only when lsu_we_i=0:
  - Only one requester valid: that requester gets ready=1.
  - Both valid: grant the one not equal to last_q.
  - last_q is updated to the granted source on every EX/AUX grant.
- Handshake:
  - A transfer occurs on valid&ready.
  - A requester must hold valid, waddr and wdata stable until granted.
  - Ready never depends on the requester's own data.
  - Ready is combinational from the valid inputs, lsu_we_i and last_q.
- Output stage (1-cycle latency):
  - At the posedge after a grant, rf_we_o=1 and rf_waddr_o/rf_wdata_o hold the winner's values.
  - With no grant, rf_we_o=0 and the address/data outputs hold their previous values.
- x0 writes:
  - A grant with waddr=0 completes the handshake but leaves rf_we_o=0.
  - It still advances last_q.
- Hazards:
  - hazard_a_o=1 iff rd_addr_a_i!=0 and either:
    - ex_valid_i & ~ex_ready_o & ex_waddr_i==rd_addr_a_i, or
    - aux_valid_i & ~aux_ready_o & aux_waddr_i==rd_addr_a_i (AuxPresent only).
  - Port B is computed the same way.
  - Granted writers and the LSU never raise a hazard.
- Starvation bound: with lsu_we_i=0 and both EX and AUX continuously valid, grants alternate every cycle. No requester waits more than 1 non-LSU cycle.
- Reset mid-operation:
  - rf_we_o drops to 0 asynchronously.
  - An in-flight registered write is lost, since the register file is also in reset.
  - last_q returns to EX.
- Assertion (non-synthesis): at most one of the LSU, EX and AUX grants is active per cycle.

Optional Feature:
- Macro: IBEX_RF_WR_ARB_PERF_EN.
- When defined, adds two outputs:
  - perf_ex_stall_o [15:0]: counts cycles with ex_valid_i&~ex_ready_o.
  - perf_aux_stall_o [15:0]: counts cycles with aux_valid_i&~aux_ready_o.
- Both counters saturate at 16'hFFFF, reset to 0, and clear synchronously on input perf_clr_i.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- EX only: ex_valid_i=1, waddr=5, wdata=32'hA5A5_0001 -> ex_ready_o=1 same cycle; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=32'hA5A5_0001.
- LSU collision: lsu_we_i=1 (waddr=3, data=32'h1234) together with ex_valid_i=1 (waddr=7) ->
  - Cycle 1: ex_ready_o=0, hazard_a_o=1 with rd_addr_a_i=7.
  - Cycle 2: rf_waddr_o=3.
  - EX is granted once lsu_we_i drops, then rf_waddr_o=7.
- Round-robin: EX and AUX both valid for 4 cycles, last_q=EX after reset -> grants AUX, EX, AUX, EX; rf_waddr_o follows that order.
- x0 write: ex_valid_i=1, waddr=0 -> ex_ready_o=1; next cycle rf_we_o=0.
- Reset mid-op: assert rst_ni=0 one cycle after an AUX grant -> rf_we_o=0 immediately. After release, both valid -> AUX is granted first.
- PERF_EN: hold aux_valid_i=1 behind 70000 consecutive LSU cycles -> perf_aux_stall_o=16'hFFFF; pulse perf_clr_i -> 0.
